// File: rtl/mitchell_antilog.sv
// mitchell_antilog: two-stage antilog for the Mitchell multiplier, computes (1.f) x 2^k truncated to an integer
module mitchell_antilog #(
   parameter int W     = 8,
   parameter int F     = W - 1,
   parameter int K     = 4,
   parameter int OUT_W = 2 * W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [K-1:0]     in_k,
   input  logic [F-1:0]     in_frac,
   input  logic             in_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_prod,
   output logic             out_ovf
);
   localparam logic [K-1:0] F_K   = K'(F);
   localparam logic [K-1:0] K_MAX = K'(2 * W - 2);
   logic             s1_valid;
   logic [K-1:0]     s1_k;
   logic [F:0]       s1_mant;
   logic             s1_zero;
   logic             s1_ovf;
   logic             s2_accept;
   logic [OUT_W-1:0] mant_ext;
   logic [OUT_W-1:0] nxt_prod;
   logic             nxt_ovf;
   assign s2_accept = !out_valid | out_ready;
   assign in_ready  = !s1_valid | s2_accept;
   assign mant_ext  = {{(OUT_W-F-1){1'b0}}, s1_mant};
   // barrel shift the mantissa by k-F, with zero taking precedence over overflow saturation
   always_comb begin
      nxt_prod = s1_zero ? '0 : s1_ovf ? '1 :
                 (s1_k >= F_K) ? mant_ext << (s1_k - F_K) : mant_ext >> (F_K - s1_k);
      nxt_ovf  = !s1_zero & s1_ovf;
   end
   // stage 1: capture the log value, form the mantissa and flag out-of-range k
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_k     <= '0;
         s1_mant  <= '0;
         s1_zero  <= 1'b0;
         s1_ovf   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_k    <= in_k;
            s1_mant <= {1'b1, in_frac};
            s1_zero <= in_zero;
            s1_ovf  <= in_k > K_MAX;
         end
      end
   end
   // stage 2: register the shifted result, holding it while downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_prod  <= '0;
         out_ovf   <= 1'b0;
      end else if (s2_accept) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_prod <= nxt_prod;
            out_ovf  <= nxt_ovf;
         end
      end
   end
endmodule

// File: doc/mitchell_antilog.md
Name: mitchell_antilog

Overview:
- Antilogarithm stage of the Mitchell approximate multiplier. It is the decode-side counterpart of the priority-encoder/log stage.
- Input: a log-domain value made of characteristic k and fraction f. The fraction is the sum of the two operand logs, including the carry into k.
- Output: the linear approximate product, (1.f) x 2^k, truncated to an integer.
- Two-stage pipeline with valid/ready handshake on both sides. Sits between the log-adder and the multiplier result register.

Parameters:
- W, 8, operand width of the multiplier.
- F, W-1, fraction width of the log-domain input.
- K, 4, characteristic width; must hold 0..2W-1, so 4 bits for W=8.
- OUT_W, 2*W, product width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input log value valid.
- in_ready  output  1  block can accept the input this cycle.
- in_k  input  K  characteristic (integer part of the log sum).
- in_frac  input  F  fraction part of the log sum.
- in_zero  input  1  one operand was zero; forces the result to 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_prod  output  OUT_W  approximate product.
- out_ovf  output  1  k out of range; out_prod is saturated.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - s1_valid=0, out_valid=0, out_prod=0, out_ovf=0. All internal pipeline registers cleared.
  - in_ready=1 once rst deasserts.
- Handshake:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - out_valid/out_prod/out_ovf stay stable while out_valid=1 and out_ready=0.
  - The input side never drops an accepted item. The output side never duplicates or reorders.
- Pipeline control:
  - s2_accept = !out_valid | out_ready.
  - s1_advance = s1_valid & s2_accept.
  - in_ready = !s1_valid | s2_accept. This is a combinational path from out_ready, which is permitted.
  - Capacity is 2 items in flight. Full-throughput case: 1 result per cycle when out_ready is held high.
- Latency: 2 cycles from an input transfer to out_valid, with no stall.
- Stage 1 (registered):
  - Captures in_k, in_frac, in_zero.
  - Computes mant = {1'b1, in_frac} (F+1 bits).
  - Computes ovf1 = (in_k > 2W-2).
- Stage 2 (registered to outputs), precedence top to bottom:
  - zero=1 -> out_prod=0, out_ovf=0.
  - else ovf1=1 -> out_prod = all ones, out_ovf=1.
  - else k >= F -> out_prod = mant << (k-F), zero-extended to OUT_W.
  - else (k < F) -> out_prod = mant >> (F-k). Dropped bits are truncated, not rounded.
  - At k = 2W-2 with full fraction, the result (2^(F+1)-1)<<(W-1) fits OUT_W; no overflow.
- Simultaneous events:
  - Input transfer and output transfer in the same cycle are both honoured.
  - Stage 1 refills while stage 2 drains.
- Reset mid-operation: all in-flight items are discarded, out_valid drops immediately, and no partial result appears after release.
- Shifter: a single-cycle barrel shifter in stage 2. The shift amount range is 0..2W-2.

Test Plan:
- Exact powers, out_ready=1:
  - k=0, frac=0 -> out_prod=1.
  - k=7, frac=0 -> 128.
  - k=14, frac=0 -> 16384.
  - Each appears exactly 2 cycles after the transfer.
- Mitchell values:
  - 3x5 log sum k=3, frac=7'b1100000 -> out_prod=14.
  - k=3, frac=7'b1000000 -> 12.
  - k=14, frac=7'h7F -> 32640, out_ovf=0.
- Special inputs:
  - in_zero=1 with k=14, frac=7'h7F -> out_prod=0, out_ovf=0.
  - k=15 -> out_prod=16'hFFFF, out_ovf=1.
- Back-pressure:
  - Hold out_ready=0 and offer 3 items (k=1,2,3, frac=0).
  - Two are accepted, then in_ready=0 and out_prod=2 is held stable.
  - Raise out_ready: outputs 2, 4, 8 in order; no loss or duplication; the third input is accepted on the cycle stage 1 advances.
- Streaming and reset:
  - 16 back-to-back inputs with random k<=14 and frac, out_ready=1 -> 1 result/cycle, matching a reference model.
  - Assert rst asynchronously mid-stream between clock edges -> out_valid=0 immediately, nothing emitted after release until new input.
